// File: rtl/bomberman_draw_engine_if.sv
// Memory-read and VGA-plot bus between the draw engine and its surroundings.
// master = draw engine, slave = memory mux / VGA adapter side.
interface bomberman_draw_engine_if;
   logic [14:0] mem_addr;
   logic [2:0]  mem_data;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;

   modport master (
      output mem_addr,
      output vga_x,
      output vga_y,
      output vga_colour,
      output vga_plot,
      input  mem_data
   );

   modport slave (
      input  mem_addr,
      input  vga_x,
      input  vga_y,
      input  vga_colour,
      input  vga_plot,
      output mem_data
   );
endinterface

// File: rtl/bomberman_draw_engine.sv
// Copy engine: walks a full screen or an 8x8 sprite, reads colours from memory and
// plots them one cycle later; also owns the stage tile counter.
module bomberman_draw_engine #(
   parameter int         SCREEN_W    = 160,
   parameter int         SCREEN_H    = 120,
   parameter int         GRID_W      = 20,
   parameter int         GRID_H      = 15,
   parameter int         SPR_P1      = 4,
   parameter int         SPR_P2      = 5,
   parameter logic [2:0] TRANSPARENT = 3'b101
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    copy_enable,
   input  logic                    draw_stage,
   input  logic                    draw_t,
   input  logic                    draw_p1,
   input  logic                    draw_p2,
   input  logic                    tc_enable,
   input  logic                    stage_reset,
   input  logic [2:0]              tile_type,
   input  logic [7:0]              p1_x,
   input  logic [6:0]              p1_y,
   input  logic [7:0]              p2_x,
   input  logic [6:0]              p2_y,
   bomberman_draw_engine_if.master draw_bus,
   output logic                    finished,
   output logic [8:0]              tile_index,
   output logic                    all_tiles_drawn
);

   localparam logic [7:0] X_LAST    = 8'(SCREEN_W - 1);
   localparam logic [6:0] Y_LAST    = 7'(SCREEN_H - 1);
   localparam logic [8:0] X_LIMIT   = 9'(SCREEN_W);
   localparam logic [7:0] Y_LIMIT   = 8'(SCREEN_H);
   localparam logic [4:0] COL_LAST  = 5'(GRID_W - 1);
   localparam logic [8:0] TILE_LAST = 9'(GRID_W * GRID_H - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t      state;
   state_t      state_next;

   logic        stage_mode;
   logic [2:0]  sprite_id;
   logic [8:0]  org_x;
   logic [7:0]  org_y;
   logic [7:0]  px;
   logic [6:0]  py;
   logic [14:0] stage_addr;

   logic        start;
   logic        last_pixel;
   logic        advance;
   logic [7:0]  x_wrap;
   logic [8:0]  pix_x;
   logic [7:0]  pix_y;
   logic        in_bounds;

   logic        plot_valid;
   logic        plot_sprite;
   logic [7:0]  plot_x;
   logic [6:0]  plot_y;

   logic [4:0]  col;
   logic [3:0]  row;

   assign start      = (state == IDLE) && copy_enable &&
                       (draw_stage || draw_t || draw_p1 || draw_p2);
   assign x_wrap     = stage_mode ? X_LAST : 8'd7;
   assign last_pixel = (px == x_wrap) && (py == (stage_mode ? Y_LAST : 7'd7));
   assign advance    = (state == RUN) && copy_enable && !last_pixel;

   // Widened sums so sprites hanging off the right/bottom edge clip instead of wrapping.
   assign pix_x     = org_x + {1'b0, px};
   assign pix_y     = org_y + {1'b0, py};
   assign in_bounds = (pix_x < X_LIMIT) && (pix_y < Y_LIMIT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      finished   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (!copy_enable) begin
               state_next = IDLE;
            end else if (last_pixel) begin
               state_next = FLUSH;
            end
         end
         FLUSH: begin
            if (!copy_enable) begin
               state_next = IDLE;
            end else begin
               state_next = DONE;
            end
         end
         DONE: begin
            finished   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage_mode  <= 1'b0;
         sprite_id   <= 3'd0;
         org_x       <= 9'd0;
         org_y       <= 8'd0;
         px          <= 8'd0;
         py          <= 7'd0;
         stage_addr  <= 15'd0;
         plot_valid  <= 1'b0;
         plot_sprite <= 1'b0;
         plot_x      <= 8'd0;
         plot_y      <= 7'd0;
      end else begin
         if (start) begin
            px         <= 8'd0;
            py         <= 7'd0;
            stage_addr <= 15'd0;
            if (draw_stage) begin
               stage_mode <= 1'b1;
               sprite_id  <= 3'd0;
               org_x      <= 9'd0;
               org_y      <= 8'd0;
            end else if (draw_t) begin
               stage_mode <= 1'b0;
               sprite_id  <= tile_type;
               org_x      <= {1'b0, col, 3'b000};
               org_y      <= {1'b0, row, 3'b000};
            end else if (draw_p1) begin
               stage_mode <= 1'b0;
               sprite_id  <= 3'(SPR_P1);
               org_x      <= {1'b0, p1_x};
               org_y      <= {1'b0, p1_y};
            end else begin
               stage_mode <= 1'b0;
               sprite_id  <= 3'(SPR_P2);
               org_x      <= {1'b0, p2_x};
               org_y      <= {1'b0, p2_y};
            end
         end else if (advance) begin
            // Stage addresses come from a running counter rather than y*SCREEN_W+x.
            stage_addr <= stage_addr + 15'd1;
            if (px == x_wrap) begin
               px <= 8'd0;
               py <= py + 7'd1;
            end else begin
               px <= px + 8'd1;
            end
         end else begin
            px         <= 8'd0;
            py         <= 7'd0;
            stage_addr <= 15'd0;
         end

         plot_valid  <= (state == RUN) && copy_enable && in_bounds;
         plot_sprite <= !stage_mode;
         if (state == RUN) begin
            plot_x <= pix_x[7:0];
            plot_y <= pix_y[6:0];
         end
      end
   end

   // Colour arrives from the memory's read register in the plot cycle itself.
   always_comb begin
      draw_bus.mem_addr = 15'd0;
      if (state == RUN) begin
         draw_bus.mem_addr = stage_mode ? stage_addr
                                        : {6'd0, sprite_id, py[2:0], px[2:0]};
      end
      draw_bus.vga_x      = plot_x;
      draw_bus.vga_y      = plot_y;
      draw_bus.vga_colour = plot_valid ? draw_bus.mem_data : 3'd0;
      draw_bus.vga_plot   = plot_valid && copy_enable &&
                            !(plot_sprite && (draw_bus.mem_data == TRANSPARENT));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col        <= 5'd0;
         row        <= 4'd0;
         tile_index <= 9'd0;
      end else if (stage_reset) begin
         col        <= 5'd0;
         row        <= 4'd0;
         tile_index <= 9'd0;
      end else if (tc_enable) begin
         if (tile_index == TILE_LAST) begin
            col        <= 5'd0;
            row        <= 4'd0;
            tile_index <= 9'd0;
         end else if (col == COL_LAST) begin
            col        <= 5'd0;
            row        <= row + 4'd1;
            tile_index <= tile_index + 9'd1;
         end else begin
            col        <= col + 5'd1;
            tile_index <= tile_index + 9'd1;
         end
      end
   end

   assign all_tiles_drawn = (tile_index == TILE_LAST);

endmodule

// File: tb/tb_bomberman_draw_engine.sv
// Randomised bench for bomberman_draw_engine: a plot-list reference model built from
// the drawing rules is compared against what the engine actually plots.
module tb_bomberman_draw_engine;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       copy_enable = 1'b0;
   logic       draw_stage = 1'b0;
   logic       draw_t = 1'b0;
   logic       draw_p1 = 1'b0;
   logic       draw_p2 = 1'b0;
   logic       tc_enable = 1'b0;
   logic       stage_reset = 1'b0;
   logic [2:0] tile_type = 3'd0;
   logic [7:0] p1_x = 8'd0;
   logic [6:0] p1_y = 7'd0;
   logic [7:0] p2_x = 8'd0;
   logic [6:0] p2_y = 7'd0;
   logic       finished;
   logic [8:0] tile_index;
   logic       all_tiles_drawn;

   bomberman_draw_engine_if bus_if ();

   bomberman_draw_engine dut (
      .clock           (clock),
      .reset           (reset),
      .copy_enable     (copy_enable),
      .draw_stage      (draw_stage),
      .draw_t          (draw_t),
      .draw_p1         (draw_p1),
      .draw_p2         (draw_p2),
      .tc_enable       (tc_enable),
      .stage_reset     (stage_reset),
      .tile_type       (tile_type),
      .p1_x            (p1_x),
      .p1_y            (p1_y),
      .p2_x            (p2_x),
      .p2_y            (p2_y),
      .draw_bus        (bus_if),
      .finished        (finished),
      .tile_index      (tile_index),
      .all_tiles_drawn (all_tiles_drawn)
   );

   always #10 clock = ~clock;

   // Memory contents: a constant colour, or an address-dependent pattern.
   int         mem_kind = 0;
   logic [2:0] const_c = 3'd0;
   int         salt = 0;

   function automatic logic [2:0] mem_fn(input int addr);
      if (mem_kind == 0) return const_c;
      return 3'(addr * 5 + salt + addr / 11);
   endfunction

   always @(posedge clock) bus_if.mem_data <= mem_fn(int'(bus_if.mem_addr));

   int tests_run = 0;
   int tests_failed = 0;
   int tiles_model = 0;
   int last_plot_x = -1;
   int last_plot_y = -1;

   typedef struct {
      int x;
      int y;
      int c;
   } plot_t;

   plot_t exp_q[$];

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tc_pulses(input int n);
      if (n > 0) begin
         tc_enable = 1'b1;
         repeat (n) @(negedge clock);
         tc_enable = 1'b0;
         tiles_model = (tiles_model + n) % 300;
      end
   endtask

   // Entered and left on a falling edge.
   task automatic run_draw(input string tag, input bit ds, input bit dt,
                           input bit dp1, input bit dp2);
      int n = 0, ox = 0, oy = 0, id = 0;
      int got = 0, bad = 0, pulses = 0, fin_j = -1;
      int first_a = -1, last_a = -1, exp_first = 0, exp_last = 0, exp_cnt = 0;
      plot_t p;
      exp_q.delete();
      if (ds) begin
         n = 19200;
         for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++) begin
               p.x = x; p.y = y; p.c = int'(mem_fn(y * 160 + x));
               exp_q.push_back(p);
            end
         exp_first = 0;
         exp_last  = 19199;
      end else begin
         n = 64;
         if (dt) begin
            id = int'(tile_type);
            ox = (tiles_model % 20) * 8;
            oy = (tiles_model / 20) * 8;
         end else if (dp1) begin
            id = 4; ox = int'(p1_x); oy = int'(p1_y);
         end else begin
            id = 5; ox = int'(p2_x); oy = int'(p2_y);
         end
         for (int sy = 0; sy < 8; sy++)
            for (int sx = 0; sx < 8; sx++) begin
               p.x = ox + sx; p.y = oy + sy; p.c = int'(mem_fn(id * 64 + sy * 8 + sx));
               if (p.x < 160 && p.y < 120 && p.c != 5) exp_q.push_back(p);
            end
         exp_first = id * 64;
         exp_last  = id * 64 + 63;
      end
      exp_cnt = exp_q.size();

      draw_stage = ds; draw_t = dt; draw_p1 = dp1; draw_p2 = dp2;
      @(negedge clock);
      draw_stage = 1'b0; draw_t = 1'b0; draw_p1 = 1'b0; draw_p2 = 1'b0;
      last_plot_x = -1;
      last_plot_y = -1;
      for (int j = 0; j < n + 8; j++) begin
         if (j == 0) first_a = int'(bus_if.mem_addr);
         if (j == n - 1) last_a = int'(bus_if.mem_addr);
         if (bus_if.vga_plot) begin
            got++;
            last_plot_x = int'(bus_if.vga_x);
            last_plot_y = int'(bus_if.vga_y);
            if (exp_q.size() == 0) bad++;
            else begin
               p = exp_q.pop_front();
               if (p.x != int'(bus_if.vga_x) || p.y != int'(bus_if.vga_y) ||
                   p.c != int'(bus_if.vga_colour)) bad++;
            end
         end
         if (finished) begin
            pulses++;
            fin_j = j;
         end
         @(negedge clock);
      end
      check({tag, "_plot_count"}, got, exp_cnt);
      check({tag, "_plot_errors"}, bad, 0);
      check({tag, "_finish_pulses"}, pulses, 1);
      check({tag, "_finish_cycle"}, fin_j, n + 1);
      check({tag, "_first_addr"}, first_a, exp_first);
      check({tag, "_last_addr"}, last_a, exp_last);
      $display("[TB] draw %s: plots=%0d/%0d finish_cycle=%0d addr %0d..%0d",
               tag, got, exp_cnt, fin_j, first_a, last_a);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_plot"}, int'(bus_if.vga_plot), 0);
      check({tag, "_finished"}, int'(finished), 0);
      check({tag, "_mem_addr"}, int'(bus_if.mem_addr), 0);
      check({tag, "_vga_x"}, int'(bus_if.vga_x), 0);
      check({tag, "_vga_y"}, int'(bus_if.vga_y), 0);
      check({tag, "_colour"}, int'(bus_if.vga_colour), 0);
      check({tag, "_tile_index"}, int'(tile_index), 0);
   endtask

   initial begin
      int pulses, plots;
      bit rt, rp1, rp2;

      repeat (3) @(negedge clock);
      check_idle_outputs("reset");
      check("reset_all_tiles", int'(all_tiles_drawn), 0);
      reset = 1'b0;
      copy_enable = 1'b1;
      @(negedge clock);

      // Plain tile at index 0
      mem_kind = 0; const_c = 3'b011; tile_type = 3'd2;
      run_draw("tile0", 1'b0, 1'b1, 1'b0, 1'b0);

      // Player 1 clipped at the bottom-right corner
      const_c = 3'b001; p1_x = 8'd156; p1_y = 7'd118;
      run_draw("p1_corner", 1'b0, 1'b0, 1'b1, 1'b0);
      check("p1_corner_last_x", last_plot_x, 159);
      check("p1_corner_last_y", last_plot_y, 119);

      // Fully transparent player 2
      const_c = 3'b101; p2_x = 8'd40; p2_y = 7'd50;
      run_draw("p2_transparent", 1'b0, 1'b0, 1'b0, 1'b1);

      // Random tiles/sprites, positions, colours and request combinations
      mem_kind = 1;
      for (int i = 0; i < 10; i++) begin
         tc_pulses(int'($urandom_range(0, 40)));
         tile_type = 3'($urandom_range(0, 7));
         p1_x = 8'($urandom_range(0, 200)); p1_y = 7'($urandom_range(0, 127));
         p2_x = 8'($urandom_range(0, 200)); p2_y = 7'($urandom_range(0, 127));
         salt = int'($urandom_range(0, 1000));
         do begin
            rt = 1'($urandom); rp1 = 1'($urandom); rp2 = 1'($urandom);
         end while (!(rt || rp1 || rp2));
         run_draw($sformatf("rand%0d", i), 1'b0, rt, rp1, rp2);
      end

      // Tile counter wrap and clear priority
      stage_reset = 1'b1; @(negedge clock); stage_reset = 1'b0; tiles_model = 0;
      check("tc_cleared", int'(tile_index), 0);
      tc_pulses(298);
      check("tc_298", int'(tile_index), 298);
      check("tc_298_all", int'(all_tiles_drawn), 0);
      tc_pulses(1);
      check("tc_299", int'(tile_index), 299);
      check("tc_299_all", int'(all_tiles_drawn), 1);
      tc_pulses(1);
      check("tc_wrap", int'(tile_index), 0);
      check("tc_wrap_all", int'(all_tiles_drawn), 0);
      tc_pulses(7);
      check("tc_7", int'(tile_index), tiles_model);
      stage_reset = 1'b1; tc_enable = 1'b1; @(negedge clock);
      stage_reset = 1'b0; tc_enable = 1'b0; tiles_model = 0;
      check("tc_reset_wins", int'(tile_index), 0);
      $display("[TB] tile counter sequence done, index=%0d", tile_index);

      // A tile somewhere in the middle of the grid
      tc_pulses(47); tile_type = 3'd7; salt = 17;
      run_draw("tile_mid", 1'b0, 1'b1, 1'b0, 1'b0);

      // Full-screen copy; stage wins over a simultaneous tile request
      salt = 3;
      run_draw("stage", 1'b1, 1'b1, 1'b0, 1'b0);
      check("stage_last_x", last_plot_x, 159);
      check("stage_last_y", last_plot_y, 119);

      // Abort a tile draw at RUN cycle 30
      draw_t = 1'b1; @(negedge clock); draw_t = 1'b0;
      repeat (30) @(negedge clock);
      copy_enable = 1'b0;
      pulses = 0; plots = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clock);
         if (finished) pulses++;
         if (bus_if.vga_plot) plots++;
      end
      copy_enable = 1'b1;
      for (int j = 0; j < 80; j++) begin
         @(negedge clock);
         if (finished) pulses++;
         if (bus_if.vga_plot) plots++;
      end
      check("abort_finished", pulses, 0);
      check("abort_plots", plots, 0);
      $display("[TB] abort tile: finished=%0d late_plots=%0d", pulses, plots);

      // Asynchronous reset in the middle of a stage draw
      tc_pulses(37);
      draw_stage = 1'b1; @(negedge clock); draw_stage = 1'b0;
      repeat (500) @(negedge clock);
      reset = 1'b1;
      #1;
      check_idle_outputs("midreset");
      tiles_model = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      pulses = 0; plots = 0;
      for (int j = 0; j < 60; j++) begin
         @(negedge clock);
         if (finished) pulses++;
         if (bus_if.vga_plot) plots++;
      end
      check("midreset_finished", pulses, 0);
      check("midreset_plots", plots, 0);
      $display("[TB] reset during stage: finished=%0d plots=%0d", pulses, plots);

      // Clean restart after the reset
      tile_type = 3'd6; salt = 99;
      run_draw("restart", 1'b0, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
